// File: rtl/sram_arb_pkg.sv
// Shared types and requester identifiers for the SLC-3 SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational 2-way request picker; the tie winner comes from the arbiter policy
// (fixed CPU priority, or round-robin when SRAM_ARB_ROUND_ROBIN_EN is defined).
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic tie_winner,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = cpu_req | dbg_req;
        grant       = REQ_CPU;
        if (cpu_req && dbg_req) begin
            grant = tie_winner;
        end else if (dbg_req) begin
            grant = REQ_DBG;
        end
    end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter sequencing the async SRAM strobes over a fixed access.
// Optional SRAM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last.
module sram_mem_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    generate
        if (WAIT_CYC < 1) begin : g_bad_wait
            $error("sram_mem_arbiter: WAIT_CYC must be >= 1");
        end
    endgenerate

    arb_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              sel_reg;
    logic              we_reg;

    logic              grant_valid;
    logic              grant;
    logic              tie_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .tie_winner  (tie_winner),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    // Starts at dbg so the very first tie goes to the CPU.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_grant_reg <= REQ_DBG;
        end else if (state_reg == IDLE && grant_valid) begin
            last_grant_reg <= grant;
        end
    end

    assign tie_winner = ~last_grant_reg;
`else
    assign tie_winner = REQ_CPU;
`endif

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (grant == REQ_DBG) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
    end

    // Strobes are loaded on the IDLE->ACCESS edge so they are active for exactly the ACCESS cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            sel_reg     <= REQ_CPU;
            we_reg      <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            Mem_CE      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            Mem_UB      <= 1'b0;
            Mem_LB      <= 1'b0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
        end else begin
            Mem_UB <= 1'b0;
            Mem_LB <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    if (grant_valid) begin
                        sel_reg     <= grant;
                        we_reg      <= sel_we;
                        sram_addr   <= sel_addr;
                        sram_dq_out <= sel_wdata;
                        cnt_reg     <= CNT_LOAD;
                        Mem_CE      <= 1'b0;
                        Mem_OE      <= sel_we;
                        Mem_WE      <= ~sel_we;
                        sram_dq_oe  <= sel_we;
                        state_reg   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == '0) begin
                        if (!we_reg) begin
                            if (sel_reg == REQ_DBG) begin
                                dbg_rdata <= sram_dq_in;
                            end else begin
                                cpu_rdata <= sram_dq_in;
                            end
                        end
                        Mem_CE     <= 1'b1;
                        Mem_OE     <= 1'b1;
                        Mem_WE     <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        cpu_ack    <= (sel_reg == REQ_CPU);
                        dbg_ack    <= (sel_reg == REQ_DBG);
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    cpu_ack   <= 1'b0;
                    dbg_ack   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
